// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use and branch-operand hazard detection.
// Freezes PC and IF/ID and inserts bubbles when forwarding cannot cover a dependency.
module id_ex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic [4:0]       IF_ID_RegisterRd,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_Branch,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_MemToReg,
    input  logic             ID_ALUSrc,
    input  logic [3:0]       ID_ALUOp,
    input  logic [XLEN-1:0]  ID_rs1_data,
    input  logic [XLEN-1:0]  ID_rs2_data,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RegisterRd,
    input  logic             ex_hold,
    input  logic             flush_ex,
    input  logic             clr_cnt,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             hazard,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic             ID_EX_MemWrite,
    output logic             ID_EX_MemToReg,
    output logic             ID_EX_ALUSrc,
    output logic [3:0]       ID_EX_ALUOp,
    output logic [XLEN-1:0]  ID_EX_rs1_data,
    output logic [XLEN-1:0]  ID_EX_rs2_data,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [4:0]       ID_EX_RegisterRs1,
    output logic [4:0]       ID_EX_RegisterRs2,
    output logic [4:0]       ID_EX_RegisterRd,
    output logic [1:0]       last_cause,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic [3:0]      aluop;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } id_ex_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LU   = 2'b01;
    localparam logic [1:0] CAUSE_BA   = 2'b10;
    localparam logic [1:0] CAUSE_BM   = 2'b11;

    id_ex_t           r_id_ex;
    id_ex_t           w_id_in;
    logic [1:0]       r_last_cause;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_m_ex;
    logic             w_m_mem;
    logic             w_lu;
    logic             w_ba;
    logic             w_bm;
    logic             w_hazard;
    logic [1:0]       w_cause;
    logic             w_bubble;
    logic             w_stall;
    logic             w_cnt_sat;

    // Source-register matches; x0 never creates a dependency.
    always_comb begin
        w_m_ex  = (r_id_ex.rd != 5'd0) &&
                  ((ID_uses_rs1 && IF_ID_RegisterRs1 == r_id_ex.rd) ||
                   (ID_uses_rs2 && IF_ID_RegisterRs2 == r_id_ex.rd));
        w_m_mem = (EX_MEM_RegisterRd != 5'd0) &&
                  ((ID_uses_rs1 && IF_ID_RegisterRs1 == EX_MEM_RegisterRd) ||
                   (ID_uses_rs2 && IF_ID_RegisterRs2 == EX_MEM_RegisterRd));
    end

    // Hazard classes and prioritised cause encoding.
    always_comb begin
        w_lu     = r_id_ex.memread && w_m_ex;
        w_ba     = ID_Branch && r_id_ex.regwrite && !r_id_ex.memread && w_m_ex;
        w_bm     = ID_Branch && EX_MEM_MemRead && w_m_mem;
        w_hazard = w_lu || w_ba || w_bm;
        w_cause  = CAUSE_NONE;
        unique case (1'b1)
            w_lu:    w_cause = CAUSE_LU;
            w_ba:    w_cause = CAUSE_BA;
            w_bm:    w_cause = CAUSE_BM;
            default: w_cause = CAUSE_NONE;
        endcase
    end

    // Per-cycle action: hold beats flush beats hazard-stall beats normal load.
    always_comb begin
        w_stall     = !ex_hold && !flush_ex && w_hazard;
        w_bubble    = !ex_hold && (flush_ex || w_hazard);
        w_cnt_sat   = &r_stall_count;
        PC_write    = !ex_hold && !w_hazard;
        IF_ID_write = !ex_hold && !w_hazard;
        hazard      = w_hazard;
    end

    // Bundle the decoded instruction for the pipeline register.
    always_comb begin
        w_id_in.regwrite = ID_RegWrite;
        w_id_in.memread  = ID_MemRead;
        w_id_in.memwrite = ID_MemWrite;
        w_id_in.memtoreg = ID_MemToReg;
        w_id_in.alusrc   = ID_ALUSrc;
        w_id_in.aluop    = ID_ALUOp;
        w_id_in.rs1_data = ID_rs1_data;
        w_id_in.rs2_data = ID_rs2_data;
        w_id_in.imm      = ID_imm;
        w_id_in.pc       = ID_pc;
        w_id_in.rs1      = IF_ID_RegisterRs1;
        w_id_in.rs2      = IF_ID_RegisterRs2;
        w_id_in.rd       = IF_ID_RegisterRd;
    end

    // ID/EX register: hold, bubble (all zero) or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_ex <= '0;
        end else if (ex_hold) begin
            r_id_ex <= r_id_ex;
        end else if (w_bubble) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_id_in;
        end
    end

    // Cause of the latest hazard bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_cause <= CAUSE_NONE;
        end else if (w_stall) begin
            r_last_cause <= w_cause;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (clr_cnt) begin
            r_stall_count <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign ID_EX_RegWrite    = r_id_ex.regwrite;
    assign ID_EX_MemRead     = r_id_ex.memread;
    assign ID_EX_MemWrite    = r_id_ex.memwrite;
    assign ID_EX_MemToReg    = r_id_ex.memtoreg;
    assign ID_EX_ALUSrc      = r_id_ex.alusrc;
    assign ID_EX_ALUOp       = r_id_ex.aluop;
    assign ID_EX_rs1_data    = r_id_ex.rs1_data;
    assign ID_EX_rs2_data    = r_id_ex.rs2_data;
    assign ID_EX_imm         = r_id_ex.imm;
    assign ID_EX_pc          = r_id_ex.pc;
    assign ID_EX_RegisterRs1 = r_id_ex.rs1;
    assign ID_EX_RegisterRs2 = r_id_ex.rs2;
    assign ID_EX_RegisterRd  = r_id_ex.rd;
    assign last_cause        = r_last_cause;
    assign stall_count       = r_stall_count;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed cycle-by-cycle vectors for id_ex_hazard_stage.
// Stall counter is narrowed so saturation is reachable.
module tb_id_ex_hazard_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam logic [31:0] DMASK = 32'h5A5A_0000;

    logic             clk;
    logic             rst_n;
    logic [4:0]       rs1, rs2, rd;
    logic             u1, u2, br;
    logic             rw, mr, mw, m2r, alusrc;
    logic [3:0]       aluop;
    logic [XLEN-1:0]  rs1_data, rs2_data, imm, pc;
    logic             exmr;
    logic [4:0]       exrd;
    logic             hold, flush, clr;
    logic             pcw, ifw, haz;
    logic             o_rw, o_mr, o_mw, o_m2r, o_alusrc;
    logic [3:0]       o_aluop;
    logic [XLEN-1:0]  o_rs1d, o_rs2d, o_imm, o_pc;
    logic [4:0]       o_rs1, o_rs2, o_rd;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
        .IF_ID_RegisterRd(rd),
        .ID_uses_rs1(u1), .ID_uses_rs2(u2), .ID_Branch(br),
        .ID_RegWrite(rw), .ID_MemRead(mr), .ID_MemWrite(mw),
        .ID_MemToReg(m2r), .ID_ALUSrc(alusrc), .ID_ALUOp(aluop),
        .ID_rs1_data(rs1_data), .ID_rs2_data(rs2_data),
        .ID_imm(imm), .ID_pc(pc),
        .EX_MEM_MemRead(exmr), .EX_MEM_RegisterRd(exrd),
        .ex_hold(hold), .flush_ex(flush), .clr_cnt(clr),
        .PC_write(pcw), .IF_ID_write(ifw), .hazard(haz),
        .ID_EX_RegWrite(o_rw), .ID_EX_MemRead(o_mr),
        .ID_EX_MemWrite(o_mw), .ID_EX_MemToReg(o_m2r),
        .ID_EX_ALUSrc(o_alusrc), .ID_EX_ALUOp(o_aluop),
        .ID_EX_rs1_data(o_rs1d), .ID_EX_rs2_data(o_rs2d),
        .ID_EX_imm(o_imm), .ID_EX_pc(o_pc),
        .ID_EX_RegisterRs1(o_rs1), .ID_EX_RegisterRs2(o_rs2),
        .ID_EX_RegisterRd(o_rd),
        .last_cause(cause), .stall_count(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, br, rw, mr;
        logic [31:0] pc;
        logic        exmr;
        logic [4:0]  exrd;
        logic        hold, flush, clr;
        logic        e_haz;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic [1:0]  e_cause;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t v(
        input logic [4:0] a1, a2, ad,
        input logic f1, f2, fb, frw, fmr,
        input logic [31:0] fpc,
        input logic fexmr, input logic [4:0] fexrd,
        input logic fh, ff, fc,
        input logic eh, input logic [31:0] epc,
        input logic [4:0] erd, input logic [1:0] ec, input logic [1:0] en
    );
        vec_t t;
        t.rs1 = a1; t.rs2 = a2; t.rd = ad;
        t.u1 = f1; t.u2 = f2; t.br = fb; t.rw = frw; t.mr = fmr;
        t.pc = fpc; t.exmr = fexmr; t.exrd = fexrd;
        t.hold = fh; t.flush = ff; t.clr = fc;
        t.e_haz = eh; t.e_pc = epc; t.e_rd = erd;
        t.e_cause = ec; t.e_cnt = en;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rs1 = t.rs1; rs2 = t.rs2; rd = t.rd;
        u1 = t.u1; u2 = t.u2; br = t.br; rw = t.rw; mr = t.mr;
        mw = 1'b0; m2r = t.mr; alusrc = t.mr; aluop = t.pc[5:2];
        pc = t.pc; rs1_data = t.pc ^ DMASK;
        rs2_data = ~t.pc; imm = t.pc + 32'h10;
        exmr = t.exmr; exrd = t.exrd;
        hold = t.hold; flush = t.flush; clr = t.clr;
    endtask

    initial begin
        vec_t z;
        logic [31:0] e_d;
        z = v(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        tbl[0]  = v(1,0,5,1,0,0,1,1,'h100,0,0,0,0,0, 0,'h100,5,0,0);
        tbl[1]  = v(5,7,6,1,1,0,1,0,'h104,0,0,0,0,0, 1,0,0,1,1);
        tbl[2]  = v(5,7,6,1,1,0,1,0,'h104,0,0,0,0,0, 0,'h104,6,1,1);
        tbl[3]  = v(1,0,3,1,0,0,1,0,'h108,0,0,0,0,0, 0,'h108,3,1,1);
        tbl[4]  = v(3,4,0,1,1,1,0,0,'h10C,0,0,0,0,0, 1,0,0,2,2);
        tbl[5]  = v(3,4,0,1,1,1,0,0,'h10C,0,0,0,0,0, 0,'h10C,0,2,2);
        tbl[6]  = v(1,0,3,1,0,0,1,0,'h110,0,0,0,0,0, 0,'h110,3,2,2);
        tbl[7]  = v(3,1,8,1,1,0,1,0,'h114,0,0,0,0,0, 0,'h114,8,2,2);
        tbl[8]  = v(2,0,9,1,0,0,1,1,'h118,0,0,0,0,1, 0,'h118,9,2,0);
        tbl[9]  = v(9,0,0,1,1,1,0,0,'h11C,0,0,0,0,0, 1,0,0,1,1);
        tbl[10] = v(9,0,0,1,1,1,0,0,'h11C,1,9,0,0,0, 1,0,0,3,2);
        tbl[11] = v(9,0,0,1,1,1,0,0,'h11C,0,0,0,0,0, 0,'h11C,0,3,2);
        tbl[12] = v(1,0,0,1,0,0,1,1,'h120,0,0,0,0,0, 0,'h120,0,3,2);
        tbl[13] = v(0,0,6,1,1,0,1,0,'h124,0,0,0,0,0, 0,'h124,6,3,2);
        tbl[14] = v(1,0,7,1,0,0,1,1,'h128,0,0,0,0,0, 0,'h128,7,3,2);
        tbl[15] = v(1,7,10,1,0,0,1,0,'h12C,0,0,0,0,0, 0,'h12C,10,3,2);
        tbl[16] = v(1,0,11,1,0,0,1,1,'h130,0,0,0,0,0, 0,'h130,11,3,2);
        tbl[17] = v(11,1,12,1,1,0,1,0,'h134,0,0,1,0,0, 1,'h130,11,3,2);
        tbl[18] = v(11,1,12,1,1,0,1,0,'h134,0,0,1,0,0, 1,'h130,11,3,2);
        tbl[19] = v(11,1,12,1,1,0,1,0,'h134,0,0,1,0,0, 1,'h130,11,3,2);
        tbl[20] = v(11,1,12,1,1,0,1,0,'h134,0,0,0,0,0, 1,0,0,1,3);
        tbl[21] = v(11,1,12,1,1,0,1,0,'h134,0,0,0,0,0, 0,'h134,12,1,3);
        tbl[22] = v(1,0,13,1,0,0,1,1,'h138,0,0,0,0,1, 0,'h138,13,1,0);
        tbl[23] = v(13,0,14,1,0,0,1,0,'h13C,0,0,0,0,0, 1,0,0,1,1);
        tbl[24] = v(13,0,14,1,0,0,1,0,'h13C,0,0,0,0,0, 0,'h13C,14,1,1);
        tbl[25] = v(20,0,0,1,1,1,0,0,'h140,1,20,0,0,0, 1,0,0,3,2);
        tbl[26] = v(20,0,0,1,1,1,0,0,'h140,1,20,0,0,0, 1,0,0,3,3);
        tbl[27] = v(20,0,0,1,1,1,0,0,'h140,1,20,0,0,0, 1,0,0,3,3);
        tbl[28] = v(20,0,0,1,1,1,0,0,'h140,1,20,0,1,0, 1,0,0,3,3);
        tbl[29] = v(20,0,0,1,1,1,0,0,'h140,1,20,0,0,1, 1,0,0,3,0);
        tbl[30] = v(20,0,0,1,1,1,0,0,'h140,0,0,0,1,0, 0,0,0,3,0);
        tbl[31] = v(20,0,0,1,1,1,0,0,'h140,0,0,0,0,0, 0,'h140,0,3,0);

        rst_n = 1'b0;
        drive(z);
        #12;
        chk("reset pc", o_pc, 0);
        chk("reset rd", {27'd0, o_rd}, 0);
        chk("reset rw", {31'd0, o_rw}, 0);
        chk("reset cause", {30'd0, cause}, 0);
        chk("reset cnt", {30'd0, cnt}, 0);
        chk("reset pcw", {31'd0, pcw}, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d hazard", i), {31'd0, haz},
                {31'd0, tbl[i].e_haz});
            chk($sformatf("row%0d pcw", i), {31'd0, pcw},
                {31'd0, !tbl[i].e_haz && !tbl[i].hold});
            chk($sformatf("row%0d ifw", i), {31'd0, ifw},
                {31'd0, !tbl[i].e_haz && !tbl[i].hold});
            @(posedge clk);
            #1;
            e_d = (tbl[i].e_pc == 0) ? 32'd0 : (tbl[i].e_pc ^ DMASK);
            chk($sformatf("row%0d pc", i), o_pc, tbl[i].e_pc);
            chk($sformatf("row%0d rs1d", i), o_rs1d, e_d);
            chk($sformatf("row%0d rd", i), {27'd0, o_rd},
                {27'd0, tbl[i].e_rd});
            chk($sformatf("row%0d cause", i), {30'd0, cause},
                {30'd0, tbl[i].e_cause});
            chk($sformatf("row%0d cnt", i), {30'd0, cnt},
                {30'd0, tbl[i].e_cnt});
        end

        // Reset in the middle of a load-use stall.
        @(negedge clk);
        drive(v(1,0,5,1,0,0,1,1,'h200,0,0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        drive(v(5,7,6,1,1,0,1,0,'h204,0,0,0,0,0, 0,0,0,0,0));
        #1;
        chk("mid hazard", {31'd0, haz}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst pc", o_pc, 0);
        chk("rst rd", {27'd0, o_rd}, 0);
        chk("rst mr", {31'd0, o_mr}, 0);
        chk("rst cnt", {30'd0, cnt}, 0);
        chk("rst hazard", {31'd0, haz}, 0);
        chk("rst pcw", {31'd0, pcw}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst pc", o_pc, 32'h204);
        chk("post rst rd", {27'd0, o_rd}, 6);
        chk("post rst cnt", {30'd0, cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
